// File: rtl/ram_store_merge.sv
// ram_store_merge
//   Store-side read-modify-write engine between a CPU store port and a
//   single-port synchronous RAM organised as 64-bit quads.
//
//   A byte/word/long/quad store is accepted in IDLE. The block then:
//     1. reads the target quad;
//     2. shifts the store data left to its byte offset;
//     3. merges the shifted data into the quad under a byte-lane mask;
//     4. writes the merged quad back.
//   A misaligned store is rejected with done+err and causes no RAM access.
//
//   Optional feature macro: RAM_STORE_QUAD_BYPASS_EN
//     defined   : an aligned quad store goes straight to WRITE with
//                 ram_wdata = req_data (no read).
//     undefined : quad stores take the full read-modify-write path.
//
//   Ports
//     clk, rst          clock; asynchronous active-high reset
//     req_valid/ready   store request handshake (ready only in IDLE)
//     req_addr          byte address; quad address is req_addr[ADDR_W-1:3]
//     req_size          00 byte, 01 word, 10 long, 11 quad
//     req_data          right-aligned store data
//     done, err         one-cycle completion pulse; err marks a rejected store
//     ram_addr          quad address, held from READ through WRITE, else 0
//     ram_re, ram_rdata RAM read strobe; data arrives the following cycle
//     ram_we, ram_wdata RAM write strobe and merged quad
module ram_store_merge #(
  parameter int RAM_QUAD_SIZE = 64,
  parameter int ADDR_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [1:0]               req_size,
  input  logic [RAM_QUAD_SIZE-1:0] req_data,
  output logic                     done,
  output logic                     err,
  output logic [ADDR_W-4:0]        ram_addr,
  output logic                     ram_re,
  input  logic [RAM_QUAD_SIZE-1:0] ram_rdata,
  output logic                     ram_we,
  output logic [RAM_QUAD_SIZE-1:0] ram_wdata
);

  localparam int LANES = RAM_QUAD_SIZE / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t                   state_reg, state_next;
  logic [ADDR_W-1:0]        addr_reg;
  logic [1:0]               size_reg;
  logic [RAM_QUAD_SIZE-1:0] data_reg;
  logic [RAM_QUAD_SIZE-1:0] wdata_reg;

  logic                     accept;
  logic                     misaligned;
  logic                     quad_bypass;
  logic [2:0]               offset;
  logic [3:0]               size_bytes;
  logic [LANES-1:0]         lane_en;
  logic [RAM_QUAD_SIZE-1:0] mask;
  logic [RAM_QUAD_SIZE-1:0] shifted;
  logic [RAM_QUAD_SIZE-1:0] merged;

  assign accept = req_valid && (state_reg == IDLE);

  // The offset must be a multiple of the access size in bytes.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0: misaligned = 1'b0;
      2'd1: misaligned = req_addr[0];
      2'd2: misaligned = |req_addr[1:0];
      2'd3: misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

`ifdef RAM_STORE_QUAD_BYPASS_EN
  assign quad_bypass = (req_size == 2'd3) && !misaligned;
`else
  assign quad_bypass = 1'b0;
`endif

  // Byte-lane mask from the latched request: lanes [offset, offset+2^size).
  // The 4-bit sum cannot overflow (at most 7 + 8).
  assign offset     = addr_reg[2:0];
  assign size_bytes = 4'd1 << size_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_en[gi] = ({1'b0, offset} <= 4'(gi)) &&
                           (4'(gi) < ({1'b0, offset} + size_bytes));
      assign mask[gi*8 +: 8] = {8{lane_en[gi]}};
    end
  endgenerate

  // Data bits above the access size shift into lanes outside the mask
  // (or off the top) and are discarded by the merge.
  assign shifted = data_reg << {offset, 3'b000};
  assign merged  = (ram_rdata & ~mask) | (shifted & mask);

  // State and request latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      size_reg  <= '0;
      data_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg <= req_addr;
        size_reg <= req_size;
        data_reg <= req_data;
        if (quad_bypass) begin
          wdata_reg <= req_data;
        end
      end
      if (state_reg == MERGE) begin
        wdata_reg <= merged;
      end
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    ram_addr   = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (misaligned) begin
            state_next = ERR;
          end else if (quad_bypass) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        ram_re     = 1'b1;
        ram_addr   = addr_reg[ADDR_W-1:3];
        state_next = MERGE;
      end
      MERGE: begin
        ram_addr   = addr_reg[ADDR_W-1:3];
        state_next = WRITE;
      end
      WRITE: begin
        ram_we     = 1'b1;
        done       = 1'b1;
        ram_addr   = addr_reg[ADDR_W-1:3];
        state_next = IDLE;
      end
      ERR: begin
        done       = 1'b1;
        err        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_wdata = wdata_reg;

endmodule

// File: tb/tb_ram_store_merge.sv
module tb_ram_store_merge;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_data;
  logic        done;
  logic        err;
  logic [12:0] ram_addr;
  logic        ram_re;
  logic [63:0] ram_rdata;
  logic        ram_we;
  logic [63:0] ram_wdata;

  ram_store_merge #(.RAM_QUAD_SIZE(64), .ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_data  (req_data),
    .done      (done),
    .err       (err),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RAM_STORE_QUAD_BYPASS_EN
  localparam int QUAD_LAT = 1;
  localparam int QUAD_RE  = 0;
`else
  localparam int QUAD_LAT = 3;
  localparam int QUAD_RE  = 1;
`endif

  // Behavioural single-port synchronous RAM.
  logic [63:0] mem [0:8191];
  int          we_count;
  logic        both_hi;

  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_count      <= we_count + 1;
    end
  end

  always @(negedge clk) begin
    if (ram_re && ram_we) both_hi = 1'b1;
  end

  int checks;
  int errors;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Issues one store and observes it until done (bounded). Cycle 1 is the
  // first cycle after the accepting edge.
  task automatic run_store(input logic [15:0] a, input logic [1:0] s, input logic [63:0] d,
                           output int lat, output logic e, output logic [63:0] wd,
                           output logic [12:0] wa, output int nre, output int nwe);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_data  = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = '0;
    lat = -1; e = 1'b0; wd = '0; wa = '0; nre = 0; nwe = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      nre += int'(ram_re);
      nwe += int'(ram_we);
      if (ram_we) begin
        wd = ram_wdata;
        wa = ram_addr;
      end
      if (done) begin
        lat = c;
        e   = err;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic [63:0] init;
    logic [63:0] exp_wdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_re;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          lat, nre, nwe, we_before;
    logic        e;
    logic [63:0] wd;
    logic [12:0] wa, q;
    logic [63:0] exp_mem;

    for (int i = 0; i < 8192; i++) mem[i] = '0;
    we_count  = 0;
    both_hi   = 1'b0;
    checks    = 0;
    errors    = 0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_data  = '0;
    ram_rdata = '0;
    rst       = 1'b0;

    //            addr     size   data                    init                    exp_wdata              err  lat       re
    vecs[0] = '{16'h0003, 2'd0, 64'h00000000000000AB, 64'h1122334455667788, 64'h11223344AB667788, 1'b0, 3,        1};
    vecs[1] = '{16'h000C, 2'd2, 64'h0000000001234567, 64'hFFFFFFFFFFFFFFFF, 64'h01234567FFFFFFFF, 1'b0, 3,        1};
    vecs[2] = '{16'h0005, 2'd1, 64'h000000000000BEEF, 64'h0123012301230123, 64'h0123012301230123, 1'b1, 1,        0};
    vecs[3] = '{16'h0010, 2'd3, 64'hDEADBEEFCAFEF00D, 64'h5555555555555555, 64'hDEADBEEFCAFEF00D, 1'b0, QUAD_LAT, QUAD_RE};
    vecs[4] = '{16'h0006, 2'd1, 64'h00000000FFFFBEEF, 64'h0011223344556677, 64'hBEEF223344556677, 1'b0, 3,        1};
    vecs[5] = '{16'h0027, 2'd0, 64'h0000000000001234, 64'hAAAAAAAAAAAAAAAA, 64'h34AAAAAAAAAAAAAA, 1'b0, 3,        1};
    vecs[6] = '{16'h0042, 2'd2, 64'h0000000011112222, 64'h7777777777777777, 64'h7777777777777777, 1'b1, 1,        0};
    vecs[7] = '{16'h004C, 2'd3, 64'h1111111111111111, 64'h9999999999999999, 64'h9999999999999999, 1'b1, 1,        0};
    vecs[8] = '{16'h0030, 2'd2, 64'hFFFFFFFFCAFEBABE, 64'h1111111122222222, 64'h11111111CAFEBABE, 1'b0, 3,        1};

    // Reset values, checked while reset is asserted.
    #1 rst = 1'b1;
    #2;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_done",      64'(done),      64'd0);
    chk("reset_err",       64'(err),       64'd0);
    chk("reset_ram_re",    64'(ram_re),    64'd0);
    chk("reset_ram_we",    64'(ram_we),    64'd0);
    chk("reset_ram_addr",  64'(ram_addr),  64'd0);
    chk("reset_ram_wdata", ram_wdata,      64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven stores.
    for (int i = 0; i < 9; i++) begin
      q = vecs[i].addr[15:3];
      mem[q] = vecs[i].init;
      run_store(vecs[i].addr, vecs[i].size, vecs[i].data, lat, e, wd, wa, nre, nwe);
      $display("store %0d addr=%h size=%0d lat=%0d err=%0b wdata=%h re=%0d we=%0d",
               i, vecs[i].addr, vecs[i].size, lat, e, wd, nre, nwe);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_err", i),     64'(e),   64'(vecs[i].exp_err));
      chk($sformatf("v%0d_re_count", i), 64'(nre), 64'(vecs[i].exp_re));
      chk($sformatf("v%0d_we_count", i), 64'(nwe), vecs[i].exp_err ? 64'd0 : 64'd1);
      if (!vecs[i].exp_err) begin
        chk($sformatf("v%0d_wdata", i),    wd,      vecs[i].exp_wdata);
        chk($sformatf("v%0d_ram_addr", i), 64'(wa), 64'(q));
      end
      @(negedge clk);
      chk($sformatf("v%0d_ready_after", i), 64'(req_ready), 64'd1);
      chk($sformatf("v%0d_mem", i), mem[q], vecs[i].exp_wdata);
    end

    // Asynchronous reset mid-cycle during READ of a store to quad 5.
    mem[5] = 64'h0F0E0D0C0B0A0908;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'h0029; req_size = 2'd0; req_data = 64'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_read_re", 64'(ram_re), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", 64'(req_ready), 64'd1);
    chk("async_rst_re",    64'(ram_re),    64'd0);
    chk("async_rst_we",    64'(ram_we),    64'd0);
    chk("async_rst_addr",  64'(ram_addr),  64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    we_before = we_count;
    repeat (4) @(negedge clk);
    chk("async_rst_no_write", 64'(we_count), 64'(we_before));
    chk("async_rst_mem5",     mem[5], 64'h0F0E0D0C0B0A0908);
    $display("abort during READ: we=%0d mem5=%h", we_count - we_before, mem[5]);

    // Reset during MERGE of a byte store: the write must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'h0029; req_size = 2'd0; req_data = 64'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_merge_addr", 64'(ram_addr), 64'd5);
    #2 rst = 1'b1;
    #1;
    chk("merge_rst_done", 64'(done), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    we_before = we_count;
    repeat (4) @(negedge clk);
    chk("merge_rst_no_write", 64'(we_count), 64'(we_before));
    chk("merge_rst_mem5",     mem[5], 64'h0F0E0D0C0B0A0908);
    $display("abort during MERGE: we=%0d mem5=%h", we_count - we_before, mem[5]);

    // A store after the abort completes normally (byte 1 of quad 5).
    run_store(16'h0029, 2'd0, 64'h77, lat, e, wd, wa, nre, nwe);
    $display("store post-abort addr=0029 lat=%0d err=%0b wdata=%h", lat, e, wd);
    chk("post_abort_latency", 64'(lat), 64'd3);
    chk("post_abort_wdata",   wd,       64'h0F0E0D0C0B0A7708);
    @(negedge clk);
    exp_mem = 64'h0F0E0D0C0B0A7708;
    chk("post_abort_mem5", mem[5], exp_mem);

    chk("re_we_exclusive", 64'(both_hi), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
